// File: rtl/regfile_mp.sv
// ---------------------------------------------------------------------------
// regfile_mp
//   Multi-ported integer register file with x0 hard-wired to zero, two write
//   ports (port 1 wins on a collision), same-cycle write-to-read bypass on the
//   architectural read ports, a non-bypassed debug read port, and a
//   sequential clear engine that zeroes one register per cycle.
//
// Parameters
//   XLEN   data width in bits
//   NREGS  register count (power of two, >= 2); AW = log2(NREGS)
//   NRD    number of architectural read ports (>= 1)
//
// Ports
//   clk, rst_n                 clock (posedge), asynchronous active-low reset
//   rd_addr_i / rd_data_o      packed read ports, port k at [k*AW +: AW] /
//                              [k*XLEN +: XLEN], combinational with bypass
//   dbg_addr_i / dbg_data_o    debug read, combinational, no bypass
//   we0_i/wa0_i/wd0_i          write port 0
//   we1_i/wa1_i/wd1_i          write port 1 (higher priority)
//   flush_req_i                start clearing all registers
//   flush_busy_o               high while the clear sequence runs
//   flush_done_o               one-cycle pulse after the last register clears
// ---------------------------------------------------------------------------
module regfile_mp #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int NRD   = 2,
    localparam int AW   = $clog2(NREGS)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NRD*AW-1:0]   rd_addr_i,
    output logic [NRD*XLEN-1:0] rd_data_o,
    input  logic [AW-1:0]       dbg_addr_i,
    output logic [XLEN-1:0]     dbg_data_o,
    input  logic                we0_i,
    input  logic [AW-1:0]       wa0_i,
    input  logic [XLEN-1:0]     wd0_i,
    input  logic                we1_i,
    input  logic [AW-1:0]       wa1_i,
    input  logic [XLEN-1:0]     wd1_i,
    input  logic                flush_req_i,
    output logic                flush_busy_o,
    output logic                flush_done_o
);

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    state_t            state;
    logic [AW-1:0]     clr_idx;
    logic [XLEN-1:0]   regs [NREGS];

    // Writes only land in IDLE when no flush is being requested; address 0
    // is never written so regs[0] stays zero by construction.
    logic wr0_ok;
    logic wr1_ok;
    assign wr0_ok = we0_i && (wa0_i != '0);
    assign wr1_ok = we1_i && (wa1_i != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
            state        <= IDLE;
            clr_idx      <= '0;
            flush_busy_o <= 1'b0;
            flush_done_o <= 1'b0;
        end else begin
            flush_done_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (flush_req_i) begin
                        // Entry edge clears x0 itself and drops any writes.
                        regs[0]      <= '0;
                        clr_idx      <= AW'(1);
                        state        <= CLEAR;
                        flush_busy_o <= 1'b1;
                    end else begin
                        if (wr0_ok) regs[wa0_i] <= wd0_i;
                        // Port 1 assigned last so it wins on a shared address.
                        if (wr1_ok) regs[wa1_i] <= wd1_i;
                    end
                end
                CLEAR: begin
                    regs[clr_idx] <= '0;
                    // Wraps to 0 after NREGS-1 within AW bits.
                    clr_idx       <= clr_idx + AW'(1);
                    if (clr_idx == AW'(NREGS - 1)) begin
                        state        <= IDLE;
                        flush_busy_o <= 1'b0;
                        flush_done_o <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Architectural reads: x0 -> 0, then port 1 bypass, then port 0 bypass,
    // then storage. Bypass only while IDLE; in CLEAR the stored (possibly
    // stale) value is returned.
    always_comb begin
        rd_data_o = '0;
        for (int k = 0; k < NRD; k++) begin
            if (rd_addr_i[k*AW +: AW] == '0) begin
                rd_data_o[k*XLEN +: XLEN] = '0;
            end else if ((state == IDLE) && we1_i && (wa1_i == rd_addr_i[k*AW +: AW])) begin
                rd_data_o[k*XLEN +: XLEN] = wd1_i;
            end else if ((state == IDLE) && we0_i && (wa0_i == rd_addr_i[k*AW +: AW])) begin
                rd_data_o[k*XLEN +: XLEN] = wd0_i;
            end else begin
                rd_data_o[k*XLEN +: XLEN] = regs[rd_addr_i[k*AW +: AW]];
            end
        end
    end

    always_comb begin
        dbg_data_o = '0;
        if (dbg_addr_i != '0) begin
            dbg_data_o = regs[dbg_addr_i];
        end
    end

endmodule

// File: tb/tb_regfile_mp.sv
// ---------------------------------------------------------------------------
// tb_regfile_mp
//   Directed bench for regfile_mp. Instance A uses default parameters
//   (32 regs, 2 read ports); instance B uses NREGS=16, NRD=3.
// ---------------------------------------------------------------------------
module tb_regfile_mp;

    logic clk;
    logic rst_n;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A: 32 x 32, two read ports
    logic [9:0]  rd_addr_a;
    logic [63:0] rd_data_a;
    logic [4:0]  dbg_addr_a;
    logic [31:0] dbg_data_a;
    logic        we0_a, we1_a;
    logic [4:0]  wa0_a, wa1_a;
    logic [31:0] wd0_a, wd1_a;
    logic        flush_req_a, busy_a, done_a;

    regfile_mp #(.XLEN(32), .NREGS(32), .NRD(2)) dut_a (
        .clk          (clk),
        .rst_n        (rst_n),
        .rd_addr_i    (rd_addr_a),
        .rd_data_o    (rd_data_a),
        .dbg_addr_i   (dbg_addr_a),
        .dbg_data_o   (dbg_data_a),
        .we0_i        (we0_a),
        .wa0_i        (wa0_a),
        .wd0_i        (wd0_a),
        .we1_i        (we1_a),
        .wa1_i        (wa1_a),
        .wd1_i        (wd1_a),
        .flush_req_i  (flush_req_a),
        .flush_busy_o (busy_a),
        .flush_done_o (done_a)
    );

    // Instance B: 16 x 32, three read ports
    logic [11:0] rd_addr_b;
    logic [95:0] rd_data_b;
    logic [3:0]  dbg_addr_b;
    logic [31:0] dbg_data_b;
    logic        we0_b, we1_b;
    logic [3:0]  wa0_b, wa1_b;
    logic [31:0] wd0_b, wd1_b;
    logic        flush_req_b, busy_b, done_b;

    regfile_mp #(.XLEN(32), .NREGS(16), .NRD(3)) dut_b (
        .clk          (clk),
        .rst_n        (rst_n),
        .rd_addr_i    (rd_addr_b),
        .rd_data_o    (rd_data_b),
        .dbg_addr_i   (dbg_addr_b),
        .dbg_data_o   (dbg_data_b),
        .we0_i        (we0_b),
        .wa0_i        (wa0_b),
        .wd0_i        (wd0_b),
        .we1_i        (we1_b),
        .wa1_i        (wa1_b),
        .wd1_i        (wd1_b),
        .flush_req_i  (flush_req_b),
        .flush_busy_o (busy_b),
        .flush_done_o (done_b)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        we0;
        logic [4:0]  wa0;
        logic [31:0] wd0;
        logic        we1;
        logic [4:0]  wa1;
        logic [31:0] wd1;
        logic [4:0]  ra0;
        logic [4:0]  ra1;
        logic [4:0]  da;
        logic [31:0] e0;
        logic [31:0] e1;
        logic [31:0] ed;
    } vec_t;

    function automatic vec_t mk(input logic we0, input logic [4:0] wa0, input logic [31:0] wd0,
                                input logic we1, input logic [4:0] wa1, input logic [31:0] wd1,
                                input logic [4:0] ra0, input logic [4:0] ra1, input logic [4:0] da,
                                input logic [31:0] e0, input logic [31:0] e1, input logic [31:0] ed);
        vec_t v;
        v.we0 = we0; v.wa0 = wa0; v.wd0 = wd0;
        v.we1 = we1; v.wa1 = wa1; v.wd1 = wd1;
        v.ra0 = ra0; v.ra1 = ra1; v.da = da;
        v.e0 = e0; v.e1 = e1; v.ed = ed;
        return v;
    endfunction

    vec_t vt [10];

    initial begin
        int cnt_busy;
        int cnt_done;
        int first_done;
        int nz;
        int done_seen;

        // Vectors: writes applied this cycle, reads checked before the edge.
        vt[0] = mk(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0,        5'd5, 5'd0, 5'd5, 32'hDEADBEEF, 32'h0,        32'h0);
        vt[1] = mk(1'b0, 5'd0, 32'h0,        1'b1, 5'd7, 32'h55,       5'd5, 5'd0, 5'd5, 32'hDEADBEEF, 32'h0,        32'hDEADBEEF);
        vt[2] = mk(1'b1, 5'd7, 32'h11,       1'b1, 5'd7, 32'h22,       5'd7, 5'd7, 5'd7, 32'h22,       32'h22,       32'h55);
        vt[3] = mk(1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,        5'd7, 5'd5, 5'd7, 32'h22,       32'hDEADBEEF, 32'h22);
        vt[4] = mk(1'b1, 5'd3, 32'hA,        1'b1, 5'd4, 32'hB,        5'd3, 5'd4, 5'd3, 32'hA,        32'hB,        32'h0);
        vt[5] = mk(1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,        5'd3, 5'd4, 5'd4, 32'hA,        32'hB,        32'hB);
        vt[6] = mk(1'b1, 5'd0, 32'hFFFF,     1'b1, 5'd0, 32'h1234,     5'd0, 5'd0, 5'd0, 32'h0,        32'h0,        32'h0);
        vt[7] = mk(1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,        5'd0, 5'd3, 5'd0, 32'h0,        32'hA,        32'h0);
        vt[8] = mk(1'b1, 5'd8, 32'h88,       1'b1, 5'd9, 32'h99,       5'd8, 5'd9, 5'd9, 32'h88,       32'h99,       32'h0);
        vt[9] = mk(1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,        5'd9, 5'd8, 5'd8, 32'h99,       32'h88,       32'h88);

        rd_addr_a = '0; dbg_addr_a = '0; we0_a = 0; we1_a = 0; wa0_a = '0; wa1_a = '0;
        wd0_a = '0; wd1_a = '0; flush_req_a = 0;
        rd_addr_b = '0; dbg_addr_b = '0; we0_b = 0; we1_b = 0; wa0_b = '0; wa1_b = '0;
        wd0_b = '0; wd1_b = '0; flush_req_b = 0;

        // Reset state
        rst_n = 1'b0;
        repeat (2) tick();
        dbg_addr_a = 5'd5;
        #1;
        check("reset_busy", 32'(busy_a), 32'h0);
        check("reset_done", 32'(done_a), 32'h0);
        check("reset_dbg_x5", dbg_data_a, 32'h0);
        rst_n = 1'b1;
        tick();

        // Table-driven read/write/bypass vectors on instance A
        for (int i = 0; i < 10; i++) begin
            we0_a = vt[i].we0; wa0_a = vt[i].wa0; wd0_a = vt[i].wd0;
            we1_a = vt[i].we1; wa1_a = vt[i].wa1; wd1_a = vt[i].wd1;
            rd_addr_a = {vt[i].ra1, vt[i].ra0};
            dbg_addr_a = vt[i].da;
            #1;
            check($sformatf("vec%0d_rd0", i), rd_data_a[31:0],  vt[i].e0);
            check($sformatf("vec%0d_rd1", i), rd_data_a[63:32], vt[i].e1);
            check($sformatf("vec%0d_dbg", i), dbg_data_a,       vt[i].ed);
            tick();
        end
        we0_a = 0; we1_a = 0;

        // Full clear on A: fill x1..x31, then flush with writes pending
        for (int i = 1; i < 32; i++) begin
            we0_a = 1'b1; wa0_a = i[4:0]; wd0_a = 32'h1000_0000 + i;
            tick();
        end
        we0_a = 1'b0;
        dbg_addr_a = 5'd31;
        #1;
        check("fill_x31", dbg_data_a, 32'h1000_001F);

        flush_req_a = 1'b1;
        we0_a = 1'b1; wa0_a = 5'd5; wd0_a = 32'hFFFF_FFFF;
        tick();
        flush_req_a = 1'b0;
        // First CLEAR cycle: stale contents, no bypass, entry-edge write lost
        we0_a = 1'b1; wa0_a = 5'd2; wd0_a = 32'h777;
        we1_a = 1'b1; wa1_a = 5'd3; wd1_a = 32'h888;
        rd_addr_a = {5'd3, 5'd2};
        dbg_addr_a = 5'd5;
        #1;
        check("clear_nobypass_rd0", rd_data_a[31:0],  32'h1000_0002);
        check("clear_nobypass_rd1", rd_data_a[63:32], 32'h1000_0003);
        check("clear_entry_write_lost", dbg_data_a, 32'h1000_0005);

        cnt_busy = 0; cnt_done = 0; first_done = -1;
        for (int c = 0; c < 40; c++) begin
            if (busy_a) cnt_busy++;
            if (done_a) begin
                cnt_done++;
                if (first_done < 0) first_done = c;
            end
            if (!busy_a) begin
                we0_a = 1'b0; we1_a = 1'b0;
            end
            tick();
        end
        check("clear32_busy_cycles", 32'(cnt_busy), 32'd31);
        check("clear32_done_pulses", 32'(cnt_done), 32'd1);
        check("clear32_done_cycle", 32'(first_done), 32'd31);

        nz = 0;
        for (int a = 0; a < 32; a++) begin
            dbg_addr_a = a[4:0];
            #1;
            if (dbg_data_a != 32'h0) nz++;
        end
        check("clear32_nonzero_regs", 32'(nz), 32'd0);
        rd_addr_a = {5'd3, 5'd2};
        #1;
        check("clear32_write_lost_x2", rd_data_a[31:0],  32'h0);
        check("clear32_write_lost_x3", rd_data_a[63:32], 32'h0);

        // Instance B: independent read ports
        for (int i = 1; i < 16; i++) begin
            we0_b = 1'b1; wa0_b = i[3:0]; wd0_b = 32'hB000_0000 + i;
            tick();
        end
        we0_b = 1'b0;
        rd_addr_b = {4'd12, 4'd7, 4'd3};
        dbg_addr_b = 4'd5;
        #1;
        check("b_rd0", rd_data_b[31:0],  32'hB000_0003);
        check("b_rd1", rd_data_b[63:32], 32'hB000_0007);
        check("b_rd2", rd_data_b[95:64], 32'hB000_000C);
        check("b_dbg", dbg_data_b,       32'hB000_0005);

        // Instance B: clear with request held high -> restart after done
        flush_req_b = 1'b1;
        tick();
        cnt_busy = 0;
        for (int c = 0; c < 15; c++) begin
            if (busy_b) cnt_busy++;
            tick();
        end
        check("clear16_busy_cycles", 32'(cnt_busy), 32'd15);
        check("clear16_done", 32'(done_b), 32'h1);
        check("clear16_idle_busy", 32'(busy_b), 32'h0);
        tick();
        check("clear16_restart_busy", 32'(busy_b), 32'h1);
        check("clear16_restart_nodone", 32'(done_b), 32'h0);
        flush_req_b = 1'b0;
        repeat (20) tick();
        check("clear16_end_busy", 32'(busy_b), 32'h0);
        nz = 0;
        for (int a = 0; a < 16; a++) begin
            dbg_addr_b = a[3:0];
            #1;
            if (dbg_data_b != 32'h0) nz++;
        end
        check("clear16_nonzero_regs", 32'(nz), 32'd0);

        // Reset mid-CLEAR on A at clear index 10
        we0_a = 1'b1; wa0_a = 5'd10; wd0_a = 32'hAAAA; tick();
        wa0_a = 5'd20; wd0_a = 32'hBBBB; tick();
        wa0_a = 5'd31; wd0_a = 32'hCCCC; tick();
        we0_a = 1'b0;
        flush_req_a = 1'b1;
        tick();
        flush_req_a = 1'b0;
        repeat (9) tick();
        dbg_addr_a = 5'd20;
        #1;
        check("midclear_busy", 32'(busy_a), 32'h1);
        check("midclear_stale_x20", dbg_data_a, 32'hBBBB);
        rst_n = 1'b0;
        #1;
        check("abort_busy", 32'(busy_a), 32'h0);
        check("abort_done", 32'(done_a), 32'h0);
        check("abort_x20", dbg_data_a, 32'h0);
        dbg_addr_a = 5'd31;
        #1;
        check("abort_x31", dbg_data_a, 32'h0);
        done_seen = 0;
        repeat (3) begin
            tick();
            if (done_a) done_seen++;
        end
        rst_n = 1'b1;
        repeat (30) begin
            tick();
            if (done_a) done_seen++;
        end
        check("abort_no_done_pulse", 32'(done_seen), 32'd0);
        check("abort_stay_idle", 32'(busy_a), 32'h0);

        // Normal operation after reset
        we0_a = 1'b1; wa0_a = 5'd6; wd0_a = 32'h1234;
        tick();
        we0_a = 1'b0;
        rd_addr_a = {5'd0, 5'd6};
        #1;
        check("post_reset_write", rd_data_a[31:0], 32'h1234);
        check("post_reset_x0", rd_data_a[63:32], 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
